aes_inv_cipher_iter: RTL and testbench

//  Iterative AES-128 decryption core: one inverse round per clock, the inverse counterpart of the

---
 rtl/aes_inv_cipher_iter.sv | 217 +++++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher. The key is expanded once into a stored schedule,
// then one inverse round is applied per clock with a fixed, data-independent latency.

package aes_inv_pkg;
  typedef enum logic [1:0] {NOKEY, KEXP, READY, DEC} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254 by repeated squaring; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction
endpackage

module aes_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);
  logic [7:0] inv, aff;

  always_comb begin
    inv = gf_inv(a);
    aff = '0;
    for (int i = 0; i < 8; i++)
      aff[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    d = aff ^ 8'h63;
  end
endmodule

module aes_inv_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);
  logic [7:0] aff;

  always_comb begin
    aff = '0;
    for (int i = 0; i < 8; i++)
      aff[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
    d = gf_inv(aff ^ 8'h05);
  end
endmodule

module aes_inv_cipher_iter
  import aes_inv_pkg::*;
#(
  parameter bit ZERO_OUT_BUSY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] text_out
);
  state_e       state_q, state_d;
  logic [3:0]   rnd_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] kw_q, blk_q, out_q;
  logic         done_q;

  logic [31:0]  rot_w, sub_w, key_t, n0, n1, n2, n3;
  logic [127:0] kexp_next, isr, isb, ark, round_out;

  // Key schedule step: kw_q holds the previous round key.
  assign rot_w = {kw_q[23:0], kw_q[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ks
    aes_sbox u_ks (.a(rot_w[8*i +: 8]), .d(sub_w[8*i +: 8]));
  end
  assign key_t     = sub_w ^ {rcon(rnd_q), 24'h0};
  assign n0        = kw_q[127:96] ^ key_t;
  assign n1        = kw_q[95:64]  ^ n0;
  assign n2        = kw_q[63:32]  ^ n1;
  assign n3        = kw_q[31:0]   ^ n2;
  assign kexp_next = {n0, n1, n2, n3};

  assign isr = inv_shift_rows(blk_q);
  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (.a(isr[8*i +: 8]), .d(isb[8*i +: 8]));
  end
  assign ark       = isb ^ rk_q[rnd_q];
  assign round_out = inv_mix_columns(ark);

  always_comb begin
    // NOTE: assign the default before any branch so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      NOKEY:   if (kld) state_d = KEXP;
      KEXP:    if (rnd_q == 4'd10) state_d = READY;
      READY:   if (kld) state_d = KEXP;
               else if (ld) state_d = DEC;
      DEC:     if (rnd_q == 4'd0) state_d = READY;
      default: state_d = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NOKEY;
      rnd_q   <= '0;
      kw_q    <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      // NOTE: the schedule array is reset on purpose so a reset leaves no key material behind.
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        NOKEY, READY: begin
          if (kld) begin
            rk_q[0] <= key;
            kw_q    <= key;
            rnd_q   <= 4'd1;
          end else if (ld && state_q == READY) begin
            blk_q <= text_in ^ rk_q[10];
            rnd_q <= 4'd9;
          end
        end
        KEXP: begin
          rk_q[rnd_q] <= kexp_next;
          kw_q        <= kexp_next;
          rnd_q       <= (rnd_q == 4'd10) ? 4'd0 : rnd_q + 4'd1;
        end
        DEC: begin
          if (rnd_q == 4'd0) begin
            out_q  <= ark;
            done_q <= 1'b1;
          end else begin
            blk_q <= round_out;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The schedule stays valid while a block is being decrypted.
  assign key_ready = (state_q == READY) || (state_q == DEC);
  assign busy      = (state_q == KEXP) || (state_q == DEC);
  assign done      = done_q;
  assign text_out  = (ZERO_OUT_BUSY && busy) ? 128'h0 : out_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors plus random keys/blocks checked against a
// byte-array AES model; a second instance exercises the output-zeroing variant.

module tb_aes_inv_cipher_iter;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst, kld, ld;
  logic [127:0] key, text_in;
  logic         key_ready, busy, done;
  logic [127:0] text_out;
  logic         key_ready_z, busy_z, done_z;
  logic [127:0] text_out_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] mrk   [11];
  logic [127:0] last_pt;

  aes_inv_cipher_iter #(.ZERO_OUT_BUSY(1'b0)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .key_ready(key_ready),
    .ld(ld), .text_in(text_in), .busy(busy), .done(done), .text_out(text_out)
  );

  aes_inv_cipher_iter #(.ZERO_OUT_BUSY(1'b1)) dut_z (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .key_ready(key_ready_z),
    .ld(ld), .text_in(text_in), .busy(busy_z), .done(done_z), .text_out(text_out_z)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s, xv;
    for (int x = 0; x < 256; x++) begin
      xv  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (xv != 8'h00 && m_mul(xv, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = xv;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127-8*(4*c+r) -: 8] ^ mrk[10][127-8*(4*c+r) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = isbox[s[r][(c-r+4)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = t[r][c] ^ mrk[rd][127-8*(4*c+r) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09);
          s[1][c] = m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d);
          s[2][c] = m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b);
          s[3][c] = m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e);
        end
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Entered in the cycle right after the kld edge (or n0 cycles later).
  task automatic wait_key_ready(input string tag, input int n0);
    int n;
    n = n0;
    while (!key_ready && n < 15) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s kexp_phase: busy=%b done=%b, required busy=1 done=0", tag, busy, done);
      end
      step();
      n++;
    end
    n_checks++;
    if (n != 10 || key_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s kexp_latency: %0d cycles key_ready=%b busy=%b, required 10 cycles key_ready=1 busy=0",
               tag, n, key_ready, busy);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input string tag);
    key = k;
    kld = 1'b1;
    step();
    kld = 1'b0;
    model_expand(k);
    wait_key_ready(tag, 0);
  endtask

  task automatic start_ld(input logic [127:0] ct);
    text_in = ct;
    ld      = 1'b1;
    step();
    ld      = 1'b0;
  endtask

  // Entered in the cycle after the ld edge; optionally pulses kld+ld with junk mid-flight.
  task automatic wait_done(input logic [127:0] exp, input string tag, input int inject_at);
    int n;
    n = 0;
    while (!done && n < 15) begin
      n_checks++;
      if (busy !== 1'b1 || key_ready !== 1'b1 || text_out !== last_pt || text_out_z !== 128'h0) begin
        n_fail++;
        $display("FAIL %s dec_phase: busy=%b key_ready=%b text_out=%h text_out_z=%h, required 1 1 %h 0",
                 tag, busy, key_ready, text_out, text_out_z, last_pt);
      end
      if (n == inject_at) begin
        ld      = 1'b1;
        kld     = 1'b1;
        text_in = rand128();
        key     = rand128();
      end
      step();
      ld  = 1'b0;
      kld = 1'b0;
      n++;
    end
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL %s ld_to_done: %0d cycles after the ld cycle, required 11", tag, n + 1);
    end
    n_checks++;
    if (text_out !== exp) begin
      n_fail++;
      $display("FAIL %s plaintext: got %h, required %h", tag, text_out, exp);
    end
    n_checks++;
    if (busy !== 1'b0 || done_z !== 1'b1 || text_out_z !== exp) begin
      n_fail++;
      $display("FAIL %s done_cycle: busy=%b done_z=%b text_out_z=%h, required 0 1 %h",
               tag, busy, done_z, text_out_z, exp);
    end
    last_pt = exp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    repeat (2) step();
    rst = 1'b0;
    last_pt = '0;
    n_checks++;
    if ({key_ready, busy, done} !== 3'b000 || text_out !== 128'h0 || text_out_z !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_state: key_ready=%b busy=%b done=%b text_out=%h, required all zero",
               key_ready, busy, done, text_out);
    end
    start_ld(CT1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ld_without_key: busy=%b done=%b key_ready=%b, required 0 0 0", busy, done, key_ready);
      end
      step();
    end
  endtask

  task automatic test_vector1();
    load_key(K1, "v1_key");
    start_ld(CT1);
    wait_done(PT1, "v1", -1);
    step();
    n_checks++;
    if (done !== 1'b0 || text_out !== PT1) begin
      n_fail++;
      $display("FAIL v1_after_done: done=%b text_out=%h, required 0 %h", done, text_out, PT1);
    end
  endtask

  task automatic test_vector2();
    load_key(K2, "v2_key");
    n_checks++;
    if (dut.rk_q[10] !== RK10) begin
      n_fail++;
      $display("FAIL v2_rk10: got %h, required %h", dut.rk_q[10], RK10);
    end
    start_ld(CT2);
    wait_done(PT2, "v2", -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      start_ld(CT2);
      wait_done(PT2, $sformatf("b2b_%0d", i), -1);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_ignore();
    key = K1;
    kld = 1'b1;
    step();
    kld = 1'b0;
    model_expand(K1);
    repeat (3) step();
    ld = 1'b1; kld = 1'b1; text_in = rand128(); key = rand128();
    step();
    ld = 1'b0; kld = 1'b0;
    wait_key_ready("kexp_ignore", 4);
    start_ld(CT1);
    wait_done(PT1, "dec_ignore", 4);
    start_ld(CT1);
    wait_done(PT1, "dec_after_ignore", -1);
  endtask

  task automatic test_reset_mid();
    start_ld(CT1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_pt = '0;
    n_checks++;
    if ({key_ready, busy, done} !== 3'b000 || text_out !== 128'h0 || text_out_z !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_mid_dec: key_ready=%b busy=%b done=%b text_out=%h, required all zero",
               key_ready, busy, done, text_out);
    end
    start_ld(CT1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done: busy=%b done=%b key_ready=%b, required 0 0 0", busy, done, key_ready);
      end
      step();
    end
    key = K2;
    kld = 1'b1;
    step();
    kld = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_kexp: key_ready=%b busy=%b, required 0 0", key_ready, busy);
    end
    load_key(K1, "rst_reload");
    start_ld(CT1);
    wait_done(PT1, "rst_reload_dec", -1);
  endtask

  task automatic test_rekey_random();
    logic [127:0] k, ct, exp;
    for (int i = 0; i < 4; i++) begin
      k   = rand128();
      key = k;
      kld = 1'b1;
      step();
      kld = 1'b0;
      n_checks++;
      if (text_out !== last_pt || key_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rekey_%0d_hold: text_out=%h key_ready=%b, required %h 0", i, text_out, key_ready, last_pt);
      end
      model_expand(k);
      wait_key_ready($sformatf("rekey_%0d", i), 0);
      ct  = rand128();
      exp = model_decrypt(ct);
      start_ld(ct);
      wait_done(exp, $sformatf("rand_%0d", i), -1);
    end
    k  = rand128();
    ct = rand128();
    key = k; text_in = ct; kld = 1'b1; ld = 1'b1;
    step();
    kld = 1'b0; ld = 1'b0;
    model_expand(k);
    wait_key_ready("kld_wins", 0);
    exp = model_decrypt(ct);
    start_ld(ct);
    wait_done(exp, "kld_wins_dec", -1);
  endtask

  initial begin
    init_tables();
    test_reset();
    test_vector1();
    test_vector2();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_rekey_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
